// File: rtl/pool_relu.sv
// 2x2 max-pool + ReLU over a 26x26 signed int8 map, producing a 13x13 map.
// Two word reads per output pixel; four pixels are packed per output word.
module pool_relu #(
  parameter logic [31:0] IN_BASE  = 32'd0,
  parameter logic [31:0] OUT_BASE = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        finish,
  output logic        M1_R_req,
  output logic [31:0] M1_addr,
  input  logic [31:0] M1_R_data,
  output logic [31:0] M3_addr,
  output logic [3:0]  M3_W_req,
  output logic [31:0] M3_W_data
);
  typedef enum logic [2:0] {IDLE, RD_TOP, RD_BOT, POOL, WRITE, DONE} state_t;

  localparam logic [7:0] LAST_PIX = 8'd168;
  localparam logic [3:0] LAST_IDX = 4'd12;

  state_t          state;
  logic [3:0]      pr, pc;
  logic [7:0]      p;
  logic [1:0][7:0] top_pair;  // [1] is the lower byte address (left column)
  logic [3:0][7:0] pack;      // [3] is lane 0, i.e. bits [31:24]

  logic [9:0]        b, adv_b;
  logic [3:0]        adv_pr, adv_pc;
  logic              last;
  logic [1:0][7:0]   bot_pair;
  logic signed [7:0] m_top, m_bot, mx;
  logic [7:0]        pix;
  logic [3:0][7:0]   pack_nxt;

  function automatic logic [9:0] top_byte(input logic [3:0] r, input logic [3:0] c);
    return 10'(r) * 10'd52 + 10'(c) * 10'd2;
  endfunction

  function automatic logic [31:0] word_of(input logic [9:0] byte_idx);
    return 32'(byte_idx >> 2);
  endfunction

  function automatic logic signed [7:0] smax(input logic signed [7:0] x,
                                             input logic signed [7:0] y);
    return (x > y) ? x : y;
  endfunction

  always_comb begin
    b      = top_byte(pr, pc);
    adv_pc = (pc == LAST_IDX) ? 4'd0 : pc + 4'd1;
    adv_pr = (pc == LAST_IDX) ? pr + 4'd1 : pr;
    adv_b  = top_byte(adv_pr, adv_pc);
    last   = (p == LAST_PIX);
    // Row stride 26 is 2 mod 4, so the bottom pair sits in the other half-word.
    bot_pair = b[1] ? M1_R_data[31:16] : M1_R_data[15:0];
    m_top    = smax(top_pair[1], top_pair[0]);
    m_bot    = smax(bot_pair[1], bot_pair[0]);
    mx       = smax(m_top, m_bot);
    pix      = mx[7] ? 8'd0 : mx;
    pack_nxt = pack;
    pack_nxt[2'd3 - p[1:0]] = pix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pr        <= '0;
      pc        <= '0;
      p         <= '0;
      top_pair  <= '0;
      pack      <= '0;
      finish    <= 1'b0;
      M1_R_req  <= 1'b0;
      M1_addr   <= '0;
      M3_addr   <= '0;
      M3_W_req  <= '0;
      M3_W_data <= '0;
    end else begin
      finish    <= 1'b0;
      M1_R_req  <= 1'b0;
      M1_addr   <= '0;
      M3_addr   <= '0;
      M3_W_req  <= '0;
      M3_W_data <= '0;
      case (state)
        IDLE: if (start) begin
          state    <= RD_TOP;
          M1_R_req <= 1'b1;
          M1_addr  <= IN_BASE + word_of(b);
        end
        RD_TOP: begin
          state    <= RD_BOT;
          M1_R_req <= 1'b1;
          M1_addr  <= IN_BASE + word_of(b + 10'd26);
        end
        RD_BOT: begin
          state    <= POOL;
          top_pair <= b[1] ? M1_R_data[15:0] : M1_R_data[31:16];
        end
        POOL: if (p[1:0] == 2'd3 || last) begin
          state     <= WRITE;
          M3_addr   <= OUT_BASE + 32'(p >> 2);
          M3_W_data <= pack_nxt;
          M3_W_req  <= last ? 4'b1000 : 4'b1111;
          pack      <= '0;
        end else begin
          state    <= RD_TOP;
          pack     <= pack_nxt;
          pr       <= adv_pr;
          pc       <= adv_pc;
          p        <= p + 8'd1;
          M1_R_req <= 1'b1;
          M1_addr  <= IN_BASE + word_of(adv_b);
        end
        WRITE: if (last) begin
          state  <= DONE;
          finish <= 1'b1;
          pr     <= '0;
          pc     <= '0;
          p      <= '0;
        end else begin
          state    <= RD_TOP;
          pr       <= adv_pr;
          pc       <= adv_pc;
          p        <= p + 8'd1;
          M1_R_req <= 1'b1;
          M1_addr  <= IN_BASE + word_of(adv_b);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pool_relu.sv
// Random and directed maps against a plain-arithmetic pooling model; memories
// are modelled around the DUT and every write/read/finish is recorded.
module tb_pool_relu;
  localparam logic [31:0] IN_B  = 32'd100;
  localparam logic [31:0] OUT_B = 32'd200;
  localparam int LIMIT = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        finish, M1_R_req;
  logic [31:0] M1_addr, M3_addr, M3_W_data;
  logic [31:0] M1_R_data = '0;
  logic [3:0]  M3_W_req;

  pool_relu #(.IN_BASE(IN_B), .OUT_BASE(OUT_B)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .M1_R_req(M1_R_req), .M1_addr(M1_addr), .M1_R_data(M1_R_data),
    .M3_addr(M3_addr), .M3_W_req(M3_W_req), .M3_W_data(M3_W_data)
  );

  always #5 clk = ~clk;

  logic [7:0]  fmap [676];
  logic [31:0] out_word [43];
  logic [3:0]  out_req [43];
  int checks = 0, failures = 0;
  int rd_cnt, wr_cnt, fin_cnt, viol, bad_addr, rw, ww, n;
  logic [31:0] rd_last, rd_prev;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // input memory, strobe hygiene and output capture
  always @(posedge clk) begin
    if (M1_R_req) begin
      rd_cnt++;
      rd_prev = rd_last;
      rd_last = M1_addr;
      if (M1_addr >= IN_B && M1_addr <= IN_B + 32'd168) begin
        rw = int'(M1_addr - IN_B);
        M1_R_data <= {fmap[4*rw], fmap[4*rw+1], fmap[4*rw+2], fmap[4*rw+3]};
      end else begin
        bad_addr++;
        M1_R_data <= 32'hDEADBEEF;
      end
    end
    if (!M1_R_req && M1_addr != 0) viol++;
    if (M3_W_req == 0 && (M3_addr != 0 || M3_W_data != 0)) viol++;
    if (M3_W_req != 0) begin
      wr_cnt++;
      if (M3_addr >= OUT_B && M3_addr <= OUT_B + 32'd42) begin
        ww = int'(M3_addr - OUT_B);
        out_word[ww] = M3_W_data;
        out_req[ww]  = M3_W_req;
      end else bad_addr++;
    end
    if (finish) fin_cnt++;
  end

  function automatic logic [7:0] exp_pix(input int p);
    int pr = p / 13, pc = p % 13;
    logic signed [7:0] m, v;
    m = 8'sh80;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++) begin
        v = fmap[26*(2*pr+dr) + 2*pc + dc];
        if (v > m) m = v;
      end
    return (m < 0) ? 8'h00 : 8'(m);
  endfunction

  function automatic logic [31:0] exp_word(input int w);
    logic [31:0] r = '0;
    for (int k = 0; k < 4; k++)
      if (4*w + k <= 168) r[31-8*k -: 8] = exp_pix(4*w + k);
    return r;
  endfunction

  task automatic clear_capture();
    rd_cnt = 0; wr_cnt = 0; fin_cnt = 0; viol = 0; bad_addr = 0;
    rd_last = '0; rd_prev = '0;
    for (int w = 0; w < 43; w++) begin
      out_word[w] = 32'hDEADBEEF;
      out_req[w]  = '0;
    end
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < 676; i++) fmap[i] = v;
  endtask

  task automatic fill_rand(input int mode);
    logic [7:0] edge_vals [4];
    edge_vals[0] = 8'h7F; edge_vals[1] = 8'h80; edge_vals[2] = 8'h00; edge_vals[3] = 8'hFF;
    for (int i = 0; i < 676; i++)
      case (mode)
        0:       fmap[i] = 8'($urandom);
        1:       fmap[i] = 8'($urandom_range(128, 255));
        default: fmap[i] = edge_vals[$urandom_range(0, 3)];
      endcase
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_finish"}, finish, 0);
    chk({tag, "_rreq"}, M1_R_req, 0);
    chk({tag, "_raddr"}, M1_addr, 0);
    chk({tag, "_waddr"}, M3_addr, 0);
    chk({tag, "_wreq"}, M3_W_req, 0);
    chk({tag, "_wdata"}, M3_W_data, 0);
  endtask

  // counts edges after the start edge until finish is seen high
  task automatic wait_done(input int p1, input int p2, input bit hold, output int cnt);
    cnt = 0;
    while (cnt < LIMIT) begin
      @(posedge clk); cnt++; #1;
      if (finish) break;
      start = hold || cnt == p1 || cnt == p2;
    end
    chk("done_in_time", finish, 1);
  endtask

  task automatic check_results(input int cnt);
    chk("cycles", cnt, 550);
    chk("writes", wr_cnt, 43);
    chk("reads", rd_cnt, 338);
    chk("finishes", fin_cnt, 1);
    chk("last_rd_top", rd_prev, IN_B + 32'd162);
    chk("last_rd_bot", rd_last, IN_B + 32'd168);
    chk("bad_addr", bad_addr, 0);
    chk("strobe_zero", viol, 0);
    for (int w = 0; w < 43; w++) begin
      chk($sformatf("word%0d", w), out_word[w], exp_word(w));
      chk($sformatf("wreq%0d", w), out_req[w], (w == 42) ? 4'b1000 : 4'b1111);
    end
  endtask

  task automatic run(input int p1, input int p2, input bit hold);
    int cnt;
    clear_capture();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = hold;
    wait_done(p1, p2, hold, cnt);
    @(posedge clk); #1;
    chk("fin_1cyc", finish, 0);
    chk("idle_rreq", M1_R_req, 0);
    check_results(cnt);
  endtask

  int snap_r, snap_w;

  initial begin
    clear_capture();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    fill_const(8'h00);
    run(-1, -1, 1'b0);

    fill_const(8'h81);
    fmap[0] = 8'h05; fmap[1] = 8'h10; fmap[26] = 8'h80; fmap[27] = 8'h0F;
    run(-1, -1, 1'b0);
    chk("quad_w0", out_word[0], 32'h10000000);

    fill_const(8'h81);
    fmap[675] = 8'h7F;
    run(-1, -1, 1'b0);
    chk("corner_w42", out_word[42], 32'h7F000000);

    for (int m = 0; m < 3; m++) begin
      fill_rand(m);
      run(-1, -1, 1'b0);
    end

    // abort mid-run, then a clean run must be unaffected by the partial word
    fill_rand(0);
    clear_capture();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (99) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_zero("midrst");
    snap_r = rd_cnt;
    snap_w = wr_cnt;
    repeat (700) @(posedge clk);
    #1;
    chk("abort_reads", rd_cnt, snap_r);
    chk("abort_writes", wr_cnt, snap_w);
    chk("abort_finish", fin_cnt, 0);
    run(-1, -1, 1'b0);

    fill_rand(0);
    run(10, 300, 1'b0);

    // start held through DONE restarts right after the single IDLE cycle
    fill_rand(2);
    run(-1, -1, 1'b1);
    clear_capture();
    @(posedge clk); #1;
    chk("restart_req", M1_R_req, 1);
    chk("restart_addr", M1_addr, IN_B);
    start = 1'b0;
    wait_done(-1, -1, 1'b0, n);
    @(posedge clk); #1;
    check_results(n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
